// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch front end.
// Entry layout, fetch state and bench filler word.
package ifetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with push, pop and flush.
// A flush with a same-cycle push leaves exactly that one entry.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;
  logic             we;
  logic [AW-1:0]    waddr;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign we      = flush ? push : do_push;
  assign waddr   = flush ? '0 : wr_ptr;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? nxt('0) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues sequential reads,
// queues responses in order and handles redirects.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err
);

  localparam int QW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  fetch_pc;
  logic [31:0]  pc_nxt;
  logic [OW-1:0] discard;
  logic [OW-1:0] discard_nxt;
  logic [OW-1:0] outstanding;
  logic [QW-1:0] occupancy;
  logic         live;

  fetch_entry_t q_din;
  fetch_entry_t q_dout;
  logic         q_push;
  logic         q_pop;
  logic         q_full;
  logic         q_empty;
  logic [31:0]  tag;
  logic         tag_full;
  logic         tag_empty;

  logic         issue;
  logic         keep;
  logic         stale;
  logic         misaligned;
  logic         credit;

  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign credit = ~q_full & ~tag_full
    & ((32'(occupancy) + 32'(outstanding))
       < 32'(DEPTH))
    & (32'(outstanding) < 32'(MAX_OUT));

  assign mem_req_valid = live & (state == FETCH)
                       & ~redirect & credit;
  assign mem_req_addr  = live ? fetch_pc : '0;
  assign issue = mem_req_valid & mem_req_ready;

  assign keep  = mem_rsp_valid & ~tag_empty
               & (discard == '0);
  assign stale = mem_rsp_valid & (discard != '0);

  assign instr_valid = ~q_empty;
  assign instr       = q_empty ? '0 : q_dout.instr;
  assign instr_pc    = q_empty ? '0 : q_dout.pc;
  assign instr_fault = q_empty ? 1'b0 : q_dout.fault;
  assign q_pop = instr_valid & instr_ready & ~redirect;

  // Queue input: fault entry on a misaligned redirect,
  // otherwise the live response with its PC tag.
  always_comb begin
    q_push = 1'b0;
    q_din  = '0;
    if (redirect) begin
      q_push       = misaligned;
      q_din.pc     = redirect_pc;
      q_din.fault  = 1'b1;
    end else begin
      q_push       = keep;
      q_din.instr  = mem_rsp_err ? '0 : mem_rsp_data;
      q_din.pc     = tag;
      q_din.fault  = mem_rsp_err;
    end
  end

  // Next state, fetch PC and stale-response count.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = fetch_pc;
    discard_nxt = discard;
    if (redirect) begin
      state_nxt   = misaligned ? FAULT : FETCH;
      pc_nxt      = {redirect_pc[31:2], 2'b00};
      discard_nxt = outstanding
                  - OW'(mem_rsp_valid);
    end else begin
      if (keep & mem_rsp_err) state_nxt = FAULT;
      if (issue) pc_nxt = fetch_pc + 32'd4;
      if (stale) discard_nxt = discard - 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Fetch PC, discard count and post-reset gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
      live     <= 1'b0;
    end else begin
      fetch_pc <= pc_nxt;
      discard  <= discard_nxt;
      live     <= 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_entries (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (occupancy)
  );

  fetch_queue #(
    .DEPTH (MAX_OUT),
    .WIDTH (32)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (mem_rsp_valid),
    .flush (1'b0),
    .din   (fetch_pc),
    .dout  (tag),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

endmodule
